// File: rtl/affine_ub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : affine_ub_pkg
//  Description : Shared types and affine address helper for the unified
//                buffer and its iterator chains.
//  Revision    : 1.0  initial release
// ============================================================================
package affine_ub_pkg;

    localparam int MAX_DIM = 4;
    localparam int CTR_W   = 16;

    typedef struct packed {
        logic [MAX_DIM-1:0][CTR_W-1:0] extent;
        logic [MAX_DIM-1:0][CTR_W-1:0] stride;
        logic [CTR_W-1:0]              offset;
    } iter_cfg_t;

    // offset + sum(stride_i * idx_i) in 32-bit signed; strides are signed,
    // indices and offset unsigned. A dim with extent 0 behaves as extent 1,
    // so its index never contributes.
    function automatic logic signed [31:0] affine_addr(
        input logic [MAX_DIM-1:0][CTR_W-1:0] idx,
        input iter_cfg_t                     cfg
    );
        logic signed [31:0] acc;
        logic signed [31:0] term_idx;
        logic signed [31:0] term_str;
        acc = $signed({16'd0, cfg.offset});
        for (int i = 0; i < MAX_DIM; i++) begin
            term_idx = $signed({16'd0, idx[i]});
            term_str = $signed({{16{cfg.stride[i][CTR_W-1]}}, cfg.stride[i]});
            if (cfg.extent[i] != '0) begin
                acc = acc + term_idx * term_str;
            end
        end
        return acc;
    endfunction

endpackage : affine_ub_pkg
`default_nettype wire

// File: rtl/affine_ub_delay.sv
`default_nettype none
// ============================================================================
//  Module      : ub_delay_sr
//  Description : Circular delay line of DELAY+1 entries carrying data plus
//                valid; write pointer runs DELAY slots ahead of read pointer.
//  Revision    : 1.0  initial release
// ============================================================================
module ub_delay_sr #(
    parameter int W     = 16,
    parameter int DELAY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    localparam int            PW     = $clog2(DELAY + 1);
    localparam logic [PW-1:0] C_LAST = PW'(DELAY);

    logic [DELAY:0] r_vld;
    logic [W-1:0]   r_dat [DELAY+1];
    logic [PW-1:0]  r_wp;
    logic [PW-1:0]  r_rp;

    // Pointers free-run; a slot is read back exactly DELAY cycles after it
    // was written. Flush only drops the valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rp  <= '0;
            r_wp  <= C_LAST;
            r_vld <= '0;
            for (int i = 0; i <= DELAY; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_rp <= (r_rp == C_LAST) ? '0 : r_rp + PW'(1);
            r_wp <= (r_wp == C_LAST) ? '0 : r_wp + PW'(1);
            if (i_flush) begin
                r_vld <= '0;
            end else begin
                r_vld[r_wp] <= i_valid;
                r_dat[r_wp] <= i_data;
            end
        end
    end

    assign o_valid = r_vld[r_rp];
    assign o_data  = r_dat[r_rp];

endmodule : ub_delay_sr
`default_nettype wire

// File: rtl/affine_ub_iter.sv
`default_nettype none
// ============================================================================
//  Module      : affine_iter
//  Description : Loop-nest counter chain with affine address, range flag and
//                last-iteration pulse for one buffer port.
//  Revision    : 1.0  initial release
// ============================================================================
module affine_iter
    import affine_ub_pkg::*;
#(
    parameter int DIM   = 3,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_flush,
    input  logic                      i_strobe,
    input  logic [DIM-1:0][CTR_W-1:0] i_extent,
    input  logic [DIM-1:0][CTR_W-1:0] i_stride,
    input  logic [CTR_W-1:0]          i_offset,
    output logic [AW-1:0]             o_addr,
    output logic                      o_in_range,
    output logic                      o_done
);

    logic [DIM-1:0][CTR_W-1:0]     r_idx;
    logic [DIM-1:0]                w_last;
    logic [DIM-1:0]                w_carry;
    logic                          w_all_last;
    logic [MAX_DIM-1:0][CTR_W-1:0] w_ext_full;
    logic [MAX_DIM-1:0][CTR_W-1:0] w_str_full;
    logic [MAX_DIM-1:0][CTR_W-1:0] w_idx_full;
    iter_cfg_t                     w_cfg;
    logic signed [31:0]            w_addr;

    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_last
            assign w_last[gi] = (i_extent[gi] == '0) ||
                                (r_idx[gi] == i_extent[gi] - CTR_W'(1));
        end
        // Unused dims are padded with extent 0 so they never contribute.
        for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_map
            if (gi < DIM) begin : g_use
                assign w_ext_full[gi] = i_extent[gi];
                assign w_str_full[gi] = i_stride[gi];
                assign w_idx_full[gi] = r_idx[gi];
            end else begin : g_pad
                assign w_ext_full[gi] = '0;
                assign w_str_full[gi] = '0;
                assign w_idx_full[gi] = '0;
            end
        end
    endgenerate

    // Ripple carry: dim i advances when every inner dim sits at its last value.
    always_comb begin
        w_carry    = '0;
        w_all_last = 1'b1;
        for (int i = 0; i < DIM; i++) begin
            w_carry[i] = w_all_last;
            w_all_last = w_all_last & w_last[i];
        end
    end

    assign w_cfg      = '{extent: w_ext_full, stride: w_str_full, offset: i_offset};
    assign w_addr     = affine_addr(w_idx_full, w_cfg);
    assign o_in_range = (w_addr >= 32'sd0) && (w_addr < 32'(DEPTH));
    assign o_addr     = w_addr[AW-1:0];
    assign o_done     = i_strobe & ~i_flush & w_all_last;

    // Counter chain; flush outranks a coincident strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (i_flush) begin
            r_idx <= '0;
        end else if (i_strobe) begin
            for (int i = 0; i < DIM; i++) begin
                if (w_carry[i]) begin
                    r_idx[i] <= w_last[i] ? '0 : r_idx[i] + CTR_W'(1);
                end
            end
        end
    end

endmodule : affine_iter
`default_nettype wire

// File: rtl/affine_ub.sv
`default_nettype none
// ============================================================================
//  Module      : affine_ub
//  Description : Unified buffer, one write port and NREAD read ports, each
//                with its own affine address generator; read-first RAM and
//                optional extra read delay.
//  Revision    : 1.0  initial release
// ============================================================================
module affine_ub
    import affine_ub_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DIM      = 3,
    parameter int NREAD    = 2,
    parameter int DEPTH    = 4096,
    parameter int AW       = $clog2(DEPTH),
    parameter int RD_DELAY = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic [DIM-1:0][CTR_W-1:0]             cfg_wr_extent,
    input  logic [DIM-1:0][CTR_W-1:0]             cfg_wr_stride,
    input  logic [CTR_W-1:0]                      cfg_wr_offset,
    input  logic [NREAD-1:0][DIM-1:0][CTR_W-1:0]  cfg_rd_extent,
    input  logic [NREAD-1:0][DIM-1:0][CTR_W-1:0]  cfg_rd_stride,
    input  logic [NREAD-1:0][CTR_W-1:0]           cfg_rd_offset,
    input  logic                                  wen,
    input  logic [DATA_W-1:0]                     wdata,
    input  logic [NREAD-1:0]                      ren,
    output logic [NREAD-1:0][DATA_W-1:0]          rdata,
    output logic [NREAD-1:0]                      rvalid,
    output logic                                  wr_done,
    output logic [NREAD-1:0]                      rd_done,
    output logic                                  addr_err
);

    logic [DATA_W-1:0]              r_ram [DEPTH];
    logic [AW-1:0]                  w_wr_addr;
    logic                           w_wr_inr;
    logic                           w_wr_fire;
    logic [NREAD-1:0][AW-1:0]       w_rd_addr;
    logic [NREAD-1:0]               w_rd_inr;
    logic [NREAD-1:0]               w_rd_fire;
    logic [NREAD-1:0][DATA_W-1:0]   r_s1_data;
    logic [NREAD-1:0]               r_s1_vld;
    logic                           w_err_evt;
    logic                           r_addr_err;

    assign w_wr_fire = wen & ~flush;
    assign w_rd_fire = ren & {NREAD{~flush}};

    affine_iter #(.DIM(DIM), .DEPTH(DEPTH), .AW(AW)) u_wr_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (flush),
        .i_strobe   (wen),
        .i_extent   (cfg_wr_extent),
        .i_stride   (cfg_wr_stride),
        .i_offset   (cfg_wr_offset),
        .o_addr     (w_wr_addr),
        .o_in_range (w_wr_inr),
        .o_done     (wr_done)
    );

    // RAM write; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (w_wr_fire && w_wr_inr) begin
            r_ram[w_wr_addr] <= wdata;
        end
    end

    generate
        for (genvar gr = 0; gr < NREAD; gr++) begin : g_rd
            affine_iter #(.DIM(DIM), .DEPTH(DEPTH), .AW(AW)) u_rd_iter (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_flush    (flush),
                .i_strobe   (ren[gr]),
                .i_extent   (cfg_rd_extent[gr]),
                .i_stride   (cfg_rd_stride[gr]),
                .i_offset   (cfg_rd_offset[gr]),
                .o_addr     (w_rd_addr[gr]),
                .o_in_range (w_rd_inr[gr]),
                .o_done     (rd_done[gr])
            );

            // Stage-1 read register; sampling the RAM before this edge's
            // write makes a same-address collision return the old word.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_vld[gr]  <= 1'b0;
                    r_s1_data[gr] <= '0;
                end else begin
                    r_s1_vld[gr] <= w_rd_fire[gr];
                    if (w_rd_fire[gr]) begin
                        r_s1_data[gr] <= w_rd_inr[gr] ? r_ram[w_rd_addr[gr]] : '0;
                    end
                end
            end

            if (RD_DELAY > 0) begin : g_dly
                ub_delay_sr #(.W(DATA_W), .DELAY(RD_DELAY)) u_dly (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .i_flush (flush),
                    .i_valid (r_s1_vld[gr]),
                    .i_data  (r_s1_data[gr]),
                    .o_valid (rvalid[gr]),
                    .o_data  (rdata[gr])
                );
            end else begin : g_nodly
                assign rvalid[gr] = r_s1_vld[gr];
                assign rdata[gr]  = r_s1_data[gr];
            end
        end
    endgenerate

    assign w_err_evt = (w_wr_fire & ~w_wr_inr) | (|(w_rd_fire & ~w_rd_inr));

    // Sticky range error; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_err <= 1'b0;
        end else if (w_err_evt) begin
            r_addr_err <= 1'b1;
        end
    end

    assign addr_err = r_addr_err;

endmodule : affine_ub
`default_nettype wire

// File: tb/tb_affine_ub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_affine_ub
//  Description : Self-checking bench for affine_ub (RD_DELAY = 3) with a
//                strobe-count based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_affine_ub;

    localparam int RDD   = 3;
    localparam int DEPTH = 4096;

    typedef struct { int due; logic [15:0] data; } rd_item_t;
    typedef struct { logic [15:0] wdata; logic exp_err; } oor_vec_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  flush;
    logic [2:0][15:0]      cfg_wr_extent, cfg_wr_stride;
    logic [15:0]           cfg_wr_offset;
    logic [1:0][2:0][15:0] cfg_rd_extent, cfg_rd_stride;
    logic [1:0][15:0]      cfg_rd_offset;
    logic                  wen;
    logic [15:0]           wdata;
    logic [1:0]            ren;
    logic [1:0][15:0]      rdata;
    logic [1:0]            rvalid;
    logic                  wr_done;
    logic [1:0]            rd_done;
    logic                  addr_err;

    affine_ub #(.DATA_W(16), .DIM(3), .NREAD(2), .DEPTH(DEPTH), .RD_DELAY(RDD)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cfg_wr_extent(cfg_wr_extent), .cfg_wr_stride(cfg_wr_stride),
        .cfg_wr_offset(cfg_wr_offset),
        .cfg_rd_extent(cfg_rd_extent), .cfg_rd_stride(cfg_rd_stride),
        .cfg_rd_offset(cfg_rd_offset),
        .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(rdata), .rvalid(rvalid), .wr_done(wr_done), .rd_done(rd_done),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    int          m_ext [3][3];
    int          m_str [3][3];
    int          m_off [3];
    int          m_cnt [3];
    logic [15:0] m_mem [DEPTH];
    logic        m_err;
    rd_item_t    rq [2][$];
    int          cyc, nvec, nerr;
    int          wd_cnt;
    int          rd_cnt [2];
    logic [15:0] cap [$];
    oor_vec_t    tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int tot(input int p);
        int t = 1;
        for (int d = 0; d < 3; d++) t = t * ((m_ext[p][d] == 0) ? 1 : m_ext[p][d]);
        return t;
    endfunction

    // Address of strobe number n: decompose n into mixed-radix digits.
    function automatic int maddr(input int p, input int n);
        int a   = m_off[p];
        int div = 1;
        int e;
        for (int d = 0; d < 3; d++) begin
            e   = (m_ext[p][d] == 0) ? 1 : m_ext[p][d];
            a   = a + m_str[p][d] * ((n / div) % e);
            div = div * e;
        end
        return a;
    endfunction

    task automatic set_port(input int p, input int e0, input int e1, input int e2,
                            input int s0, input int s1, input int s2, input int off);
        m_ext[p][0] = e0; m_ext[p][1] = e1; m_ext[p][2] = e2;
        m_str[p][0] = s0; m_str[p][1] = s1; m_str[p][2] = s2;
        m_off[p] = off;
    endtask

    task automatic apply_cfg();
        for (int d = 0; d < 3; d++) begin
            cfg_wr_extent[d] = 16'(m_ext[0][d]);
            cfg_wr_stride[d] = 16'(m_str[0][d]);
            for (int r = 0; r < 2; r++) begin
                cfg_rd_extent[r][d] = 16'(m_ext[r+1][d]);
                cfg_rd_stride[r][d] = 16'(m_str[r+1][d]);
            end
        end
        cfg_wr_offset = 16'(m_off[0]);
        for (int r = 0; r < 2; r++) cfg_rd_offset[r] = 16'(m_off[r+1]);
    endtask

    task automatic model_step();
        logic       exp_wd;
        logic [1:0] exp_rd;
        int         a;
        rd_item_t   it;
        exp_wd = 1'b0;
        exp_rd = 2'b00;
        if (flush) begin
            for (int p = 0; p < 3; p++) m_cnt[p] = 0;
            rq[0].delete();
            rq[1].delete();
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (ren[r]) begin
                    a      = maddr(r + 1, m_cnt[r+1]);
                    it.due = cyc + 1 + RDD;
                    if (a >= 0 && a < DEPTH) it.data = m_mem[a];
                    else begin it.data = 16'h0; m_err = 1'b1; end
                    rq[r].push_back(it);
                    exp_rd[r]  = (m_cnt[r+1] == tot(r + 1) - 1);
                    m_cnt[r+1] = (m_cnt[r+1] + 1) % tot(r + 1);
                end
            end
            if (wen) begin
                a = maddr(0, m_cnt[0]);
                if (a >= 0 && a < DEPTH) m_mem[a] = wdata;
                else m_err = 1'b1;
                exp_wd   = (m_cnt[0] == tot(0) - 1);
                m_cnt[0] = (m_cnt[0] + 1) % tot(0);
            end
        end
        chk("wr_done", 32'(wr_done), 32'(exp_wd));
        chk("rd_done", 32'(rd_done), 32'(exp_rd));
        if (wr_done) wd_cnt++;
        for (int r = 0; r < 2; r++) if (rd_done[r]) rd_cnt[r]++;
    endtask

    task automatic monitor();
        logic ev;
        for (int r = 0; r < 2; r++) begin
            ev = (rq[r].size() > 0) && (rq[r][0].due == cyc);
            chk($sformatf("rvalid%0d", r), 32'(rvalid[r]), 32'(ev));
            if (ev) begin
                chk($sformatf("rdata%0d", r), 32'(rdata[r]), 32'(rq[r][0].data));
                void'(rq[r].pop_front());
            end
        end
        chk("addr_err", 32'(addr_err), 32'(m_err));
    endtask

    // Entered at a falling edge with inputs already driven.
    task automatic tick();
        #1;
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic tick_cap();
        tick();
        if (rvalid[0]) cap.push_back(rdata[0]);
    endtask

    task automatic do_flush();
        flush = 1'b1; wen = 1'b0; ren = 2'b00;
        tick();
        flush = 1'b0;
    endtask

    task automatic drain();
        ren = 2'b00; wen = 1'b0;
        repeat (RDD + 2) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ren_cyc, seen, nseen;

        for (int i = 0; i < 10; i++) begin
            tbl[i].wdata   = 16'h0B00 + 16'(i);
            tbl[i].exp_err = (i >= 6);
        end

        nvec = 0; nerr = 0; cyc = 0; wd_cnt = 0; rd_cnt[0] = 0; rd_cnt[1] = 0;
        rst_n = 1'b0; flush = 1'b0; wen = 1'b0; ren = 2'b00; wdata = 16'h0;
        for (int p = 0; p < 3; p++) begin
            set_port(p, 1, 1, 1, 0, 0, 0, 0);
            m_cnt[p] = 0;
        end
        m_err = 1'b0;
        apply_cfg();

        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_addr_err", 32'(addr_err), 32'h0);
        chk("rst_done", 32'({wr_done, rd_done}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- raster fill, raster readback and transpose readback ----
        set_port(0, 64, 64, 1, 1, 64, 0, 0);
        set_port(1, 64, 64, 1, 1, 64, 0, 0);
        set_port(2, 64, 64, 1, 64, 1, 0, 0);
        apply_cfg();
        do_flush();
        wd_cnt = 0;
        for (int n = 0; n < 4096; n++) begin
            wen = 1'b1; wdata = 16'(n);
            tick();
        end
        wen = 1'b0;
        chk("wr_done_pulses", 32'(wd_cnt), 32'd1);
        rd_cnt[0] = 0; rd_cnt[1] = 0;
        for (int n = 0; n < 4096; n++) begin
            ren = 2'b11;
            tick();
        end
        drain();
        chk("rd_done0_pulses", 32'(rd_cnt[0]), 32'd1);
        chk("rd_done1_pulses", 32'(rd_cnt[1]), 32'd1);
        chk("raster_addr_err", 32'(addr_err), 32'd0);

        // ---- latency: single strobe, then a burst through pointer wrap ----
        set_port(1, 16, 1, 1, 1, 0, 0, 0);
        apply_cfg();
        do_flush();
        ren_cyc = cyc;
        ren = 2'b01;
        tick();
        ren = 2'b00;
        seen = -1; nseen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rvalid[0]) begin nseen++; seen = cyc; end
        end
        chk("lat_count", 32'(nseen), 32'd1);
        chk("lat_cycle", 32'(seen - ren_cyc), 32'(1 + RDD));
        for (int k = 0; k < 12; k++) begin
            ren = 2'b01;
            tick();
        end
        drain();

        // ---- read-first collision at address 5 ----
        set_port(0, 1, 1, 1, 0, 0, 0, 5);
        set_port(1, 1, 1, 1, 0, 0, 0, 5);
        apply_cfg();
        do_flush();
        cap.delete();
        wen = 1'b1; wdata = 16'hAAAA; ren = 2'b00;
        tick_cap();
        wen = 1'b1; wdata = 16'h5555; ren = 2'b01;
        tick_cap();
        wen = 1'b0; ren = 2'b01;
        tick_cap();
        ren = 2'b00;
        repeat (RDD + 2) tick_cap();
        chk("collide_count", 32'(cap.size()), 32'd2);
        if (cap.size() == 2) begin
            chk("collide_old", 32'(cap[0]), 32'hAAAA);
            chk("collide_new", 32'(cap[1]), 32'h5555);
        end

        // ---- out-of-range writes from offset 4090 ----
        set_port(0, 10, 1, 1, 1, 0, 0, 4090);
        apply_cfg();
        do_flush();
        for (int i = 0; i < 10; i++) begin
            wen = 1'b1; wdata = tbl[i].wdata;
            tick();
            chk($sformatf("oor_err_%0d", i), 32'(addr_err), 32'(tbl[i].exp_err));
        end
        wen = 1'b0;
        do_flush();
        chk("err_sticky_flush", 32'(addr_err), 32'd1);
        set_port(1, 6, 1, 1, 1, 0, 0, 4090);
        set_port(2, 4, 1, 1, 1, 0, 0, 0);
        apply_cfg();
        do_flush();
        cap.delete();
        for (int k = 0; k < 6; k++) begin
            ren = 2'b11;
            tick_cap();
        end
        ren = 2'b00;
        repeat (RDD + 2) tick_cap();
        chk("oor_land_count", 32'(cap.size()), 32'd6);
        for (int k = 0; k < 6 && k < cap.size(); k++)
            chk($sformatf("oor_land_%0d", k), 32'(cap[k]), 32'(tbl[k].wdata));

        // ---- flush at iteration 100 of a 4096 burst ----
        set_port(1, 64, 64, 1, 1, 64, 0, 7);
        apply_cfg();
        do_flush();
        for (int k = 0; k < 100; k++) begin
            ren = 2'b01;
            tick();
        end
        flush = 1'b1; ren = 2'b01;
        tick();
        flush = 1'b0;
        cap.delete();
        ren = 2'b01;
        tick_cap();
        ren = 2'b00;
        repeat (RDD + 2) tick_cap();
        chk("flush_count", 32'(cap.size()), 32'd1);
        if (cap.size() == 1) chk("flush_first", 32'(cap[0]), 32'(m_mem[7]));

        // ---- randomized traffic ----
        for (int blk = 0; blk < 15; blk++) begin
            for (int p = 0; p < 3; p++) begin
                for (int d = 0; d < 3; d++) begin
                    m_ext[p][d] = int'($urandom_range(0, 5));
                    m_str[p][d] = int'($urandom_range(0, 10)) - 3;
                end
                m_off[p] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4000, 4095))
                                                        : int'($urandom_range(0, 3500));
            end
            apply_cfg();
            do_flush();
            for (int k = 0; k < 150; k++) begin
                wen   = 1'($urandom_range(0, 1));
                wdata = 16'($urandom);
                ren   = 2'($urandom_range(0, 3));
                flush = ($urandom_range(0, 40) == 0);
                tick();
            end
            flush = 1'b0;
        end
        drain();

        // ---- asynchronous reset in the middle of a read burst ----
        set_port(1, 64, 64, 1, 1, 64, 0, 0);
        set_port(2, 64, 64, 1, 64, 1, 0, 0);
        apply_cfg();
        do_flush();
        for (int k = 0; k < 6; k++) begin
            ren = 2'b11;
            tick();
        end
        chk("pre_rst_rvalid", 32'(rvalid), 32'h3);
        ren = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rvalid", 32'(rvalid), 32'h0);
        chk("async_rst_rdata0", 32'(rdata[0]), 32'h0);
        chk("async_rst_rdata1", 32'(rdata[1]), 32'h0);
        chk("async_rst_err", 32'(addr_err), 32'h0);
        for (int p = 0; p < 3; p++) m_cnt[p] = 0;
        rq[0].delete();
        rq[1].delete();
        m_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_port(0, 1, 1, 1, 0, 0, 0, 100);
        set_port(1, 1, 1, 1, 0, 0, 0, 100);
        apply_cfg();
        wen = 1'b1; wdata = 16'h1234;
        tick();
        wen = 1'b0; ren = 2'b01;
        tick();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_affine_ub
`default_nettype wire
